// File: rtl/video_scaler_tb.sv
// video_scaler_tb: triple-buffered integer-scale frame scaler with palette lookup
module video_scaler_tb #(
  parameter int SRC_W = 160,
  parameter int SRC_H = 144,
  parameter int PIX_W = 2,
  parameter int SCALE = 3,
  parameter int COLOR_W = 16,
  parameter logic [COLOR_W-1:0] BORDER = '0
) (
  input  logic               pclk,
  input  logic               rst_n,
  input  logic               in_sof,
  input  logic               in_valid,
  input  logic [PIX_W-1:0]   in_pixel,
  input  logic               de,
  input  logic               hsync,
  input  logic               vsync,
  input  logic               mirror_x,
  input  logic               mirror_y,
  input  logic               pal_we,
  input  logic [PIX_W-1:0]   pal_idx,
  input  logic [COLOR_W-1:0] pal_data,
  output logic [COLOR_W-1:0] color,
  output logic               out_de,
  output logic [7:0]         drop_cnt
);
  localparam int N = SRC_W * SRC_H;
  localparam int PN = 1 << PIX_W;
  localparam int AW = $clog2(N + 1);
  localparam int XW = $clog2(SRC_W + 1);
  localparam int YW = $clog2(SRC_H + 1);
  localparam int CW = $clog2(SCALE + 1);
  localparam logic [AW-1:0] A_END = AW'(N);
  localparam logic [AW-1:0] A_LAST = AW'(N - 1);
  localparam logic [XW-1:0] X_LAST = XW'(SRC_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(SRC_H - 1);
  localparam logic [CW-1:0] C_LAST = CW'(SCALE - 1);
  logic [PIX_W-1:0] mem [3][N];
  logic [COLOR_W-1:0] pal [PN];
  logic [1:0] wb, rb, db;
  logic fresh, vs_q, de_q, mx, my, hdone, vdone, v1, w1;
  logic [AW-1:0] addr, wa, ra;
  logic [XW-1:0] sx;
  logic [YW-1:0] sy;
  logic [CW-1:0] cx, cy;
  logic [PIX_W-1:0] rd_pix;
  logic we, comp, vs_fall, drop, in_win, x_wrap, y_adv, y_wrap;
  always_comb begin
    wa = in_sof ? '0 : addr;
    we = in_valid & (in_sof | (addr < A_END));
    comp = we & (wa == A_LAST);
    vs_fall = vs_q & ~vsync;
    drop = (in_sof & (addr != '0) & (addr < A_END)) | (comp & fresh);
    in_win = de & ~hdone & ~vdone;
    x_wrap = cx == C_LAST;
    y_adv = de_q & ~de & ~vdone;
    y_wrap = cy == C_LAST;
    ra = AW'((my ? SRC_H - 1 - int'(sy) : int'(sy)) * SRC_W + (mx ? SRC_W - 1 - int'(sx) : int'(sx)));
  end
  always_ff @(posedge pclk)
    if (we & rst_n) mem[wb][wa] <= in_pixel;
  always_ff @(posedge pclk or negedge rst_n)
    if (!rst_n) begin
      wb <= 2'd0;
      rb <= 2'd1;
      db <= 2'd2;
      fresh <= 1'b0;
      addr <= '0;
      drop_cnt <= '0;
      vs_q <= 1'b0;
      de_q <= 1'b0;
      mx <= 1'b0;
      my <= 1'b0;
      sx <= '0;
      sy <= '0;
      cx <= '0;
      cy <= '0;
      hdone <= 1'b0;
      vdone <= 1'b0;
      rd_pix <= '0;
      v1 <= 1'b0;
      w1 <= 1'b0;
      out_de <= 1'b0;
      color <= '0;
      for (int i = 0; i < PN; i++)
        pal[i] <= COLOR_W'((longint'(PN - 1 - i) * ((longint'(1) << COLOR_W) - 1)) / longint'(PN - 1));
    end else begin
      vs_q <= vsync;
      de_q <= de;
      addr <= (in_sof | we) ? wa + AW'(we) : addr;
      drop_cnt <= drop_cnt + 8'(drop & (drop_cnt != 8'hff));
      if (comp & vs_fall) begin
        db <= wb;
        wb <= rb;
        rb <= db;
        fresh <= 1'b0;
      end else if (comp) begin
        rb <= wb;
        wb <= rb;
        fresh <= 1'b1;
      end else if (vs_fall & fresh) begin
        db <= rb;
        rb <= db;
        fresh <= 1'b0;
      end
      if (vs_fall) begin
        mx <= mirror_x;
        my <= mirror_y;
      end
      if (!vsync) begin
        sx <= '0;
        sy <= '0;
        cx <= '0;
        cy <= '0;
        hdone <= 1'b0;
        vdone <= 1'b0;
      end else begin
        if (!hsync) begin
          sx <= '0;
          cx <= '0;
          hdone <= 1'b0;
        end else if (in_win) begin
          cx <= x_wrap ? '0 : cx + 1'b1;
          sx <= x_wrap ? ((sx == X_LAST) ? '0 : sx + 1'b1) : sx;
          hdone <= x_wrap & (sx == X_LAST);
        end
        if (y_adv) begin
          cy <= y_wrap ? '0 : cy + 1'b1;
          sy <= y_wrap ? ((sy == Y_LAST) ? '0 : sy + 1'b1) : sy;
          vdone <= y_wrap & (sy == Y_LAST);
        end
      end
      rd_pix <= mem[db][ra];
      v1 <= de;
      w1 <= in_win;
      out_de <= v1;
      color <= ~v1 ? '0 : w1 ? pal[rd_pix] : BORDER;
      if (pal_we) pal[pal_idx] <= pal_data;
    end
endmodule

// File: tb/tb_video_scaler_tb.sv
// tb_video_scaler_tb: randomized frame/display checks against a frame-level reference model
module tb_video_scaler_tb;
  localparam int W = 160;
  localparam int H = 8;
  localparam int S = 3;
  localparam int N = W * H;
  localparam logic [15:0] BRD = 16'h1234;
  logic pclk = 0, rst_n = 0, in_sof = 0, in_valid = 0, de = 0, hsync = 1, vsync = 1;
  logic mirror_x = 0, mirror_y = 0, pal_we = 0;
  logic [1:0] in_pixel = 0, pal_idx = 0;
  logic [15:0] pal_data = 0;
  logic [15:0] color;
  logic out_de;
  logic [7:0] drop_cnt;
  int checks = 0, errors = 0, drops = 0, line = 0;
  logic [1:0] src [N];
  logic [1:0] disp [N];
  logic [1:0] ready [N];
  logic rdy = 0, mx = 0, my = 0;
  logic [15:0] pal_m [4];
  logic [15:0] grey [4] = '{16'hFFFF, 16'hAAAA, 16'h5555, 16'h0000};
  always #5 pclk = ~pclk;
  initial begin
    #5000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  video_scaler_tb #(.SRC_W(W), .SRC_H(H), .PIX_W(2), .SCALE(S), .COLOR_W(16), .BORDER(BRD)) dut (
    .pclk(pclk), .rst_n(rst_n), .in_sof(in_sof), .in_valid(in_valid), .in_pixel(in_pixel),
    .de(de), .hsync(hsync), .vsync(vsync), .mirror_x(mirror_x), .mirror_y(mirror_y),
    .pal_we(pal_we), .pal_idx(pal_idx), .pal_data(pal_data),
    .color(color), .out_de(out_de), .drop_cnt(drop_cnt)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic cyc;
    @(posedge pclk);
    #1;
  endtask
  function automatic void ramp;
    for (int i = 0; i < 4; i++) pal_m[i] = 16'((3 - i) * 32'hFFFF / 3);
  endfunction
  function automatic void fill_rand;
    for (int i = 0; i < N; i++) src[i] = 2'($urandom);
  endfunction
  function automatic void vs_model;
    if (rdy) begin
      disp = ready;
      rdy = 0;
    end
    mx = mirror_x;
    my = mirror_y;
    line = 0;
  endfunction
  function automatic void complete(input bit vs_co);
    if (rdy) drops++;
    if (vs_co) begin
      disp = src;
      rdy = 0;
      vs_model();
    end else begin
      ready = src;
      rdy = 1;
    end
  endfunction
  function automatic logic [15:0] expc(input int r, input int k);
    int x, y;
    if (k >= W * S || r >= H * S) return BRD;
    y = r / S;
    x = k / S;
    return pal_m[disp[(my ? H - 1 - y : y) * W + (mx ? W - 1 - x : x)]];
  endfunction
  task automatic send(input int n, input bit vs_last);
    for (int i = 0; i < n; i++) begin
      in_sof = i == 0;
      in_valid = 1;
      in_pixel = src[i];
      if (vs_last && i == N - 1) vsync = 0;
      cyc();
    end
    in_sof = 0;
    in_valid = 0;
    vsync = 1;
    if (n == N) complete(vs_last);
  endtask
  task automatic vs_pulse;
    vsync = 0;
    cyc();
    vs_model();
    vsync = 1;
    cyc();
  endtask
  task automatic show(input int len, input int pt, input logic [1:0] pi, input logic [15:0] pd);
    logic [15:0] ec [$];
    logic ed [$];
    hsync = 0;
    cyc();
    hsync = 1;
    cyc();
    for (int k = 0; k < len + 3; k++) begin
      de = k < len;
      pal_we = k == pt;
      pal_idx = pi;
      pal_data = pd;
      if (k == pt) pal_m[pi] = pd;
      ec.push_back(de ? expc(line, k) : 16'h0);
      ed.push_back(de);
      cyc();
      if (k >= 1) begin
        check("out_de", 32'(out_de), 32'(ed.pop_front()));
        check("color", 32'(color), 32'(ec.pop_front()));
      end
    end
    pal_we = 0;
    de = 0;
    line++;
  endtask
  initial begin
    ramp();
    cyc();
    cyc();
    check("rst_color", 32'(color), 0);
    check("rst_out_de", 32'(out_de), 0);
    check("rst_drop", 32'(drop_cnt), 0);
    check("rst_w", 32'(dut.wb), 0);
    check("rst_r", 32'(dut.rb), 1);
    check("rst_d", 32'(dut.db), 2);
    check("rst_fresh", 32'(dut.fresh), 0);
    rst_n = 1;
    cyc();
    for (int i = 0; i < N; i++) src[i] = 2'((i % W) % 4);
    send(N, 0);
    vs_pulse();
    check("d_after_first", 32'(dut.db), 0);
    show(W * S, -1, 0, 0);
    show(W * S, -1, 0, 0);
    fill_rand();
    send(500, 0);
    drops++;
    vs_pulse();
    show(W * S, -1, 0, 0);
    show(W * S, -1, 0, 0);
    fill_rand();
    send(N, 0);
    check("drop_partial", 32'(drop_cnt), 32'(drops));
    vs_pulse();
    for (int r = 0; r < 3; r++) show(W * S, -1, 0, 0);
    fill_rand();
    send(N, 0);
    fill_rand();
    send(N, 0);
    check("drop_overrun", 32'(drop_cnt), 32'(drops));
    vs_pulse();
    for (int r = 0; r < 4; r++) show(W * S, -1, 0, 0);
    fill_rand();
    send(N, 1);
    check("coincide_fresh", 32'(dut.fresh), 0);
    check("coincide_distinct", 32'(dut.wb != dut.rb && dut.rb != dut.db && dut.wb != dut.db), 1);
    check("coincide_drop", 32'(drop_cnt), 32'(drops));
    for (int r = 0; r < 3; r++) show(W * S, -1, 0, 0);
    fill_rand();
    send(N, 0);
    mirror_x = 1;
    vs_pulse();
    mirror_x = 0;
    check("mirror_first", 32'(expc(0, 0)), 32'(pal_m[disp[W - 1]]));
    for (int r = 0; r < H * S + 1; r++) show(W * S + 10, r == 1 ? 100 : -1, 2'd1, 16'hBEEF);
    mirror_y = 1;
    vs_pulse();
    mirror_y = 0;
    for (int r = 0; r < 4; r++) show(W * S, -1, 0, 0);
    hsync = 0;
    cyc();
    hsync = 1;
    cyc();
    de = 1;
    repeat (50) cyc();
    #2 rst_n = 0;
    #1;
    check("midrst_color", 32'(color), 0);
    check("midrst_out_de", 32'(out_de), 0);
    check("midrst_drop", 32'(drop_cnt), 0);
    for (int i = 0; i < 4; i++) check("midrst_pal", 32'(dut.pal[i]), 32'(grey[i]));
    de = 0;
    cyc();
    cyc();
    rst_n = 1;
    ramp();
    drops = 0;
    rdy = 0;
    mx = 0;
    my = 0;
    cyc();
    fill_rand();
    send(N, 0);
    vs_pulse();
    for (int r = 0; r < 2; r++) show(W * S, -1, 0, 0);
    check("post_rst_drop", 32'(drop_cnt), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
